// File: rtl/sdp_ram_pkg.sv
// rtl/sdp_ram_pkg.sv - shared types and default geometry for the simple dual-port RAM
// Controller state enum and default DATA_W/ADDR_W/DEPTH constants.
package sdp_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DEPTH  = 128;

endpackage

// File: rtl/sdp_ram_clear_fsm.sv
// rtl/sdp_ram_clear_fsm.sv - post-reset memory clear sequencer
// Walks addresses 0..DEPTH-1 once after reset, then parks in READY.
module sdp_ram_clear_fsm
  import sdp_ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
      clr_we   <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          // Leaving on the cycle that writes the last word keeps CLEAR exactly DEPTH cycles long.
          if (clr_addr == LAST_ADDR) begin
            state    <= READY;
            clr_addr <= '0;
            busy     <= 1'b0;
            clr_we   <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        READY: begin
          busy   <= 1'b0;
          clr_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/param_sdp_ram.sv
// rtl/param_sdp_ram.sv - simple dual-port RAM with byte enables, write-first bypass and self-clear
// Optional SDP_RAM_OUT_REG_EN adds an output register stage (read latency 2 instead of 1).
module param_sdp_ram
  import sdp_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W/8-1:0] wr_be_i,
  input  logic                rd_en_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_valid_o,
  output logic                init_busy_o
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  sdp_ram_clear_fsm #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_fsm (
    .clk      (clk_i),
    .rst      (rst_i),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign init_busy_o = busy;

  logic wr_in_range;
  logic rd_in_range;
  logic wr_ok;
  logic rd_ok;
  logic wr_hit;

  assign wr_in_range = ({1'b0, wr_addr_i} < DEPTH_LIM);
  assign rd_in_range = ({1'b0, rd_addr_i} < DEPTH_LIM);
  assign wr_ok       = wr_en_i & ~busy & wr_in_range;
  assign rd_ok       = rd_en_i & ~busy;
  assign wr_hit      = wr_ok & (wr_addr_i == rd_addr_i);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] rd_word;

  assign old_word = rd_in_range ? mem[rd_addr_i] : '0;

  // Write-first: lanes being written this cycle bypass the array.
  always_comb begin
    rd_word = old_word;
    if (wr_hit) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be_i[i]) rd_word[8*i +: 8] = wr_data_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (clr_we) begin
        mem[clr_addr] <= '0;
      end else if (wr_ok) begin
        for (int i = 0; i < BE_W; i++) begin
          if (wr_be_i[i]) mem[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
        end
      end
    end
  end

  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_ok;
      if (rd_ok) rd_data_q <= rd_word;
    end
  end

`ifdef SDP_RAM_OUT_REG_EN
  logic [DATA_W-1:0] rd_data_q2;
  logic              rd_valid_q2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q2  <= '0;
      rd_valid_q2 <= 1'b0;
    end else begin
      rd_valid_q2 <= rd_valid_q;
      if (rd_valid_q) rd_data_q2 <= rd_data_q;
    end
  end

  assign rd_data_o  = rd_data_q2;
  assign rd_valid_o = rd_valid_q2;
`else
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
`endif

endmodule

// File: tb/tb_param_sdp_ram.sv
// tb/tb_param_sdp_ram.sv - scoreboard bench for param_sdp_ram (DEPTH 128 and DEPTH 100 side by side)
module tb_param_sdp_ram;

`ifdef SDP_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_q = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [6:0]  wr_addr = '0;
  logic [6:0]  rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;

  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, busy_a, busy_b;

  always #5 clk = ~clk;

  param_sdp_ram #(.DATA_W(32), .ADDR_W(7), .DEPTH(128)) dut_a (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a),
    .rd_valid_o(rd_valid_a), .init_busy_o(busy_a)
  );

  param_sdp_ram #(.DATA_W(32), .ADDR_W(7), .DEPTH(100)) dut_b (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
    .rd_valid_o(rd_valid_b), .init_busy_o(busy_b)
  );

  typedef struct packed {
    int          due;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_a [128];
  logic [31:0] mem_b [100];
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          mon_on = 1'b0;

  always @(posedge clk) begin
    cyc++;
    rst_q <= rst;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_models();
    for (int i = 0; i < 128; i++) mem_a[i] = '0;
    for (int i = 0; i < 100; i++) mem_b[i] = '0;
  endtask

  // One READY-state cycle: optional write and optional read, expectations from the models.
  task automatic op(input bit we, input logic [6:0] wa, input logic [31:0] wd,
                    input logic [3:0] be, input bit re, input logic [6:0] ra);
    exp_t e;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra;
    if (re) begin
      e.due = cyc + LAT;
      e.a = mem_a[ra];
      if (we && wa == ra) e.a = merge(e.a, wd, be);
      e.b = '0;
      if (ra < 7'd100) begin
        e.b = mem_b[ra];
        if (we && wa == ra) e.b = merge(e.b, wd, be);
      end
      sb.push_back(e);
    end
    if (we) begin
      mem_a[wa] = merge(mem_a[wa], wd, be);
      if (wa < 7'd100) mem_b[wa] = merge(mem_b[wa], wd, be);
    end
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    while (sb.size() > 0 && sb[sb.size()-1].due >= cyc + 1) void'(sb.pop_back());
  endtask

  task automatic measure_clear(input int exp_a, input int exp_b);
    int na, nb;
    na = 0;
    nb = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (busy_a) na++;
      if (busy_b) nb++;
      if (!busy_a && !busy_b) break;
    end
    check("busy_len_a", 32'(na), 32'(exp_a));
    check("busy_len_b", 32'(nb), 32'(exp_b));
  endtask

  always @(negedge clk) begin : mon
    bit exp_v;
    if (mon_on) begin
      exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      if (rst_q) begin
        last_a = '0;
        last_b = '0;
      end
      check("valid_a", {31'b0, rd_valid_a}, {31'b0, exp_v});
      check("valid_b", {31'b0, rd_valid_b}, {31'b0, exp_v});
      if (exp_v) begin
        check("data_a", rd_data_a, sb[0].a);
        check("data_b", rd_data_b, sb[0].b);
        last_a = sb[0].a;
        last_b = sb[0].b;
        void'(sb.pop_front());
      end else begin
        check("hold_a", rd_data_a, last_a);
        check("hold_b", rd_data_b, last_b);
      end
    end
  end

  initial begin
    clear_models();
    rst = 1'b1;
    tick();
    mon_on = 1'b1;
    @(negedge clk);
    check("rst_busy_a", {31'b0, busy_a}, 32'd1);
    check("rst_busy_b", {31'b0, busy_b}, 32'd1);
    check("rst_data_a", rd_data_a, 32'h0);
    tick();
    rst = 1'b0;
    measure_clear(128, 100);

    op(0, 7'h00, 32'h0, 4'h0, 1, 7'h00);
    op(0, 7'h00, 32'h0, 4'h0, 1, 7'h7F);
    op(1, 7'h04, 32'h11223344, 4'hF, 0, 7'h00);
    op(1, 7'h04, 32'hAABBCCDD, 4'b0101, 0, 7'h00);
    op(0, 7'h00, 32'h0, 4'h0, 1, 7'h04);
    op(1, 7'h05, 32'h00000022, 4'h1, 1, 7'h05);
    op(1, 7'h06, 32'hFFFFFFFF, 4'h0, 0, 7'h00);
    op(0, 7'h00, 32'h0, 4'h0, 1, 7'h06);
    op(1, 7'h01, 32'h000000A1, 4'hF, 0, 7'h00);
    op(1, 7'h02, 32'h000000A2, 4'hF, 0, 7'h00);
    op(1, 7'h03, 32'h000000A3, 4'hF, 0, 7'h00);
    op(0, 7'h00, 32'h0, 4'h0, 1, 7'h01);
    op(0, 7'h00, 32'h0, 4'h0, 1, 7'h02);
    op(0, 7'h00, 32'h0, 4'h0, 1, 7'h03);
    op(1, 7'h04, 32'h55667788, 4'b1010, 1, 7'h04);
    op(1, 7'h70, 32'hDEADBEEF, 4'hF, 0, 7'h00);
    op(0, 7'h00, 32'h0, 4'h0, 1, 7'h70);
    op(1, 7'h63, 32'hCAFEF00D, 4'hF, 0, 7'h00);
    op(0, 7'h00, 32'h0, 4'h0, 1, 7'h63);
    repeat (3) tick();

    // Read then reset on the next cycle: whatever is still in the pipeline must vanish.
    op(0, 7'h00, 32'h0, 4'h0, 1, 7'h04);
    assert_reset();
    tick();
    tick();
    @(negedge clk);
    check("rst2_busy_a", {31'b0, busy_a}, 32'd1);
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 7'h00; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 7'h04;
    repeat (50) tick();
    check("mid_clear_busy_a", {31'b0, busy_a}, 32'd1);
    assert_reset();
    tick();
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst = 1'b0;
    clear_models();
    measure_clear(128, 100);

    op(0, 7'h00, 32'h0, 4'h0, 1, 7'h00);
    op(0, 7'h00, 32'h0, 4'h0, 1, 7'h04);
    op(0, 7'h00, 32'h0, 4'h0, 1, 7'h63);

    for (int k = 0; k < 10; k++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check("drain", 32'(sb.size()), 32'd0);
    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/param_sdp_ram.md
PARAM_SDP_RAM -- requirements
Module: param_sdp_ram

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: data word width, multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 7: address width.
REQ-003 The block SHALL have parameter DEPTH, default 128: number of words, 1 <= DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL have port clk_i, input, 1: the single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 The block SHALL have port wr_en_i, input, 1: write request.
REQ-007 The block SHALL have port wr_addr_i, input, ADDR_W: write address.
REQ-008 The block SHALL have port wr_data_i, input, DATA_W: write data.
REQ-009 The block SHALL have port wr_be_i, input, DATA_W/8: byte enables; bit n selects wr_data_i[8n+7:8n].
REQ-010 The block SHALL have port rd_en_i, input, 1: read request.
REQ-011 The block SHALL have port rd_addr_i, input, ADDR_W: read address.
REQ-012 The block SHALL have port rd_data_o, output, DATA_W: read data.
REQ-013 The block SHALL have port rd_valid_o, output, 1: rd_data_o carries the result of a read this cycle.
REQ-014 The block SHALL have port init_busy_o, output, 1: memory clear in progress; requests ignored.

Function
REQ-015 The controller SHALL have states CLEAR and READY; reset enters CLEAR with the clear counter at 0.
REQ-016 In CLEAR the block SHALL write all-zero to address counter each cycle, incrementing by 1; after writing DEPTH-1 it SHALL enter READY next cycle (CLEAR lasts exactly DEPTH cycles).
REQ-017 init_busy_o SHALL be 1 exactly while in CLEAR; wr_en_i and rd_en_i SHALL be ignored in CLEAR.
REQ-018 In READY a write SHALL update only the byte lanes with wr_be_i set; lanes with wr_be_i clear keep prior contents; wr_be_i all-zero is a no-op.
REQ-019 In READY, rd_en_i at edge N SHALL present the word on rd_data_o with rd_valid_o=1 after edge N+1 (read latency 1).
REQ-020 rd_valid_o SHALL be 0 in any cycle not following an accepted read; rd_data_o SHALL hold its last value when no read is returned.
REQ-021 Same-cycle read and write to the same address SHALL return write-first data: enabled lanes from wr_data_i, other lanes from old contents.
REQ-022 Writes with wr_addr_i >= DEPTH SHALL be discarded; reads with rd_addr_i >= DEPTH SHALL return all-zero with rd_valid_o=1.
REQ-023 Back-to-back reads on consecutive cycles SHALL each return one result per cycle, in order, with no bubbles.

Reset
REQ-024 While rst_i is sampled 1: rd_data_o=0, rd_valid_o=0, init_busy_o=1, state=CLEAR, counter=0, all pipeline valids cleared.
REQ-025 Reset asserted mid-CLEAR or mid-read SHALL discard in-flight reads and restart the clear from address 0.

Configuration
REQ-026 Macro SDP_RAM_OUT_REG_EN SHALL be the only compile-time feature switch.
REQ-027 With SDP_RAM_OUT_REG_EN defined, an extra output register stage SHALL make read latency 2, with rd_valid_o delayed identically and REQ-021 collision data preserved through the stage.
REQ-028 Without SDP_RAM_OUT_REG_EN, read latency SHALL be 1 and no output register stage SHALL exist.

Structure
REQ-029 Package sdp_ram_pkg SHALL hold the CLEAR/READY state enum typedef and the default DATA_W/ADDR_W/DEPTH constants.
REQ-030 The clear state machine and counter SHALL be sub-module sdp_ram_clear_fsm, outputting busy, clear write enable and clear address.

Verification (DATA_W=32, ADDR_W=7, DEPTH=128 unless stated)
REQ-031 Reset 2 cycles, release -> init_busy_o=1 for exactly 128 cycles, then 0; reads of 0x00 and 0x7F return 0x00000000.
REQ-032 Write 0x11223344 to 0x04 with be=4'hF, then write 0xAABBCCDD to 0x04 with be=4'b0101, read 0x04 -> 0x11BB33DD with rd_valid_o=1 one cycle later (two with SDP_RAM_OUT_REG_EN).
REQ-033 Location 0x05 holds 0x00000000; same cycle write 0x00000022 to 0x05 be=4'h1 and read 0x05 -> 0x00000022.
REQ-034 Reads of 0x01,0x02,0x03 on three consecutive cycles after writing 0xA1,0xA2,0xA3 -> three consecutive valid results 0xA1,0xA2,0xA3.
REQ-035 DEPTH=100: write 0xDEADBEEF to 0x70, read 0x70 -> 0x00000000 with rd_valid_o=1; 0x63 writable and readable.
REQ-036 Assert rst_i at CLEAR counter 50 with a read in flight -> rd_valid_o=0, clear restarts at 0, init_busy_o=1 for another 128 cycles.
